// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants for the pipeline register chain: default
//               payload width, the NOP (all-zero) word and the classic
//               five-stage pipeline register indices.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // A bubble is encoded as an all-zero payload word.
  localparam logic [DEFAULT_DATA_WIDTH-1:0] NOP_WORD = '0;

  // Stage indices for the usual IF/ID .. MEM/WB register chain.
  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_reg_chain_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain_if
// Description : Payload/handshake bundle of the pipeline register chain.
//               The master feeds stage 0 and observes the chain output; the
//               slave is the chain itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_reg_chain_if
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid
  );

endinterface : pipe_reg_chain_if
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : One pipeline stage register (payload + valid) with flush,
//               hold and load controls. Loading an invalid source writes the
//               NOP word so bubbles always carry a clean payload.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter bit FLUSH_NEEDS_EN = 1'b0
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  ld,
  input  wire logic                  hold,
  input  wire logic                  flush,
  input  wire logic [DATA_WIDTH-1:0] src_data,
  input  wire logic                  src_valid,
  output logic      [DATA_WIDTH-1:0] data_q,
  output logic                       valid_q
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  w_do_flush;

  // Legacy mode lets a held stage ignore its flush; otherwise flush wins.
  assign w_do_flush = flush && (!FLUSH_NEEDS_EN || !hold);

  // Stage register: reset, then flush, then hold, then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= DATA_WIDTH'(NOP_WORD);
      r_valid <= 1'b0;
    end else if (w_do_flush) begin
      r_data  <= DATA_WIDTH'(NOP_WORD);
      r_valid <= 1'b0;
    end else if (hold) begin
      r_data  <= r_data;
      r_valid <= r_valid;
    end else if (ld) begin
      r_data  <= src_valid ? src_data : DATA_WIDTH'(NOP_WORD);
      r_valid <= src_valid;
    end
  end

  assign data_q  = r_data;
  assign valid_q = r_valid;

endmodule : pipe_stage_reg
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain
// Description : Chain of NUM_STAGES stage registers sharing hazard control.
//               Owns the backward hold chain (with optional bubble
//               collapsing), the occupancy popcount and a saturating counter
//               of output bubble cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int NUM_STAGES      = MEM_WB + 1,
  parameter bit FLUSH_NEEDS_EN  = 1'b0,
  parameter bit BUBBLE_COLLAPSE = 1'b0,
  parameter int CNT_WIDTH       = 16
) (
  input  wire logic                               clk,
  input  wire logic                               rst,
  pipe_reg_chain_if.slave                         bus,
  input  wire logic [NUM_STAGES-1:0]              stall,
  input  wire logic [NUM_STAGES-1:0]              flush,
  output logic      [$clog2(NUM_STAGES+1)-1:0]    occupancy,
  output logic      [CNT_WIDTH-1:0]               bubble_cnt
);

  localparam int                   OCC_W     = $clog2(NUM_STAGES + 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] w_data_q [NUM_STAGES];
  logic [NUM_STAGES-1:0] w_valid_q;
  logic [NUM_STAGES-1:0] w_hold;
  logic [OCC_W-1:0]      w_occ;
  logic [CNT_WIDTH-1:0]  r_bubble_cnt;

  // Hold propagates from the output end backwards; with collapsing enabled
  // an empty stage breaks the chain so upstream items can close the gap.
  always_comb begin
    logic v_blk;
    v_blk  = 1'b0;
    w_hold = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      v_blk     = (stall[i] | v_blk) & ~(BUBBLE_COLLAPSE & ~w_valid_q[i]);
      w_hold[i] = v_blk;
    end
  end

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic [DATA_WIDTH-1:0] w_src_data;
    logic                  w_src_valid;

    if (i == 0) begin : g_head
      assign w_src_data  = bus.in_data;
      assign w_src_valid = bus.in_valid;
    end else begin : g_body
      // A held predecessor does not advance, so this stage sees a bubble.
      assign w_src_data  = w_data_q[i-1];
      assign w_src_valid = w_valid_q[i-1] & ~w_hold[i-1];
    end

    pipe_stage_reg #(
      .DATA_WIDTH     (DATA_WIDTH),
      .FLUSH_NEEDS_EN (FLUSH_NEEDS_EN)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .ld        (~w_hold[i]),
      .hold      (w_hold[i]),
      .flush     (flush[i]),
      .src_data  (w_src_data),
      .src_valid (w_src_valid),
      .data_q    (w_data_q[i]),
      .valid_q   (w_valid_q[i])
    );
  end

  // Number of stages currently holding a valid item.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_occ = w_occ + OCC_W'(w_valid_q[i]);
    end
  end

  // Count cycles without an output item; saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!w_valid_q[NUM_STAGES-1] && (r_bubble_cnt != c_CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = ~w_hold[0];
  assign bus.out_data  = w_data_q[NUM_STAGES-1];
  assign bus.out_valid = w_valid_q[NUM_STAGES-1];
  assign occupancy     = w_occ;
  assign bubble_cnt    = r_bubble_cnt;

endmodule : pipe_reg_chain
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_reg_chain
// Description : Self-checking bench for pipe_reg_chain. Four configurations
//               (default, legacy flush, bubble collapse, 4-bit counter) share
//               one stimulus stream and are compared each cycle against an
//               item-level reference model, plus directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_chain;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int NDUT = 4;

  // Per-configuration settings: 0 default, 1 legacy flush, 2 collapse, 3 small counter
  localparam bit          FNE  [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit          BC   [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam int unsigned CMAX [NDUT] = '{65535, 65535, 65535, 15};

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic [N-1:0] stall;
  logic [N-1:0] flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_reg_chain_if #(.DATA_WIDTH(W)) if_a ();
  pipe_reg_chain_if #(.DATA_WIDTH(W)) if_b ();
  pipe_reg_chain_if #(.DATA_WIDTH(W)) if_c ();
  pipe_reg_chain_if #(.DATA_WIDTH(W)) if_d ();

  assign if_a.in_data = in_data;  assign if_a.in_valid = in_valid;
  assign if_b.in_data = in_data;  assign if_b.in_valid = in_valid;
  assign if_c.in_data = in_data;  assign if_c.in_valid = in_valid;
  assign if_d.in_data = in_data;  assign if_d.in_valid = in_valid;

  logic [2:0]  occ_a, occ_b, occ_c, occ_d;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic [3:0]  cnt_d;

  pipe_reg_chain #(.DATA_WIDTH(W), .NUM_STAGES(N), .FLUSH_NEEDS_EN(1'b0),
                   .BUBBLE_COLLAPSE(1'b0), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .bus(if_a), .stall(stall), .flush(flush),
    .occupancy(occ_a), .bubble_cnt(cnt_a));
  pipe_reg_chain #(.DATA_WIDTH(W), .NUM_STAGES(N), .FLUSH_NEEDS_EN(1'b1),
                   .BUBBLE_COLLAPSE(1'b0), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .bus(if_b), .stall(stall), .flush(flush),
    .occupancy(occ_b), .bubble_cnt(cnt_b));
  pipe_reg_chain #(.DATA_WIDTH(W), .NUM_STAGES(N), .FLUSH_NEEDS_EN(1'b0),
                   .BUBBLE_COLLAPSE(1'b1), .CNT_WIDTH(16)) u_c (
    .clk(clk), .rst(rst), .bus(if_c), .stall(stall), .flush(flush),
    .occupancy(occ_c), .bubble_cnt(cnt_c));
  pipe_reg_chain #(.DATA_WIDTH(W), .NUM_STAGES(N), .FLUSH_NEEDS_EN(1'b0),
                   .BUBBLE_COLLAPSE(1'b0), .CNT_WIDTH(4)) u_d (
    .clk(clk), .rst(rst), .bus(if_d), .stall(stall), .flush(flush),
    .occupancy(occ_d), .bubble_cnt(cnt_d));

  // Observed outputs gathered per configuration
  logic         t_ready  [NDUT];
  logic         t_ovalid [NDUT];
  logic [W-1:0] t_odata  [NDUT];
  logic [2:0]   t_occ    [NDUT];
  logic [15:0]  t_cnt    [NDUT];

  assign t_ready[0] = if_a.in_ready;  assign t_ovalid[0] = if_a.out_valid;
  assign t_ready[1] = if_b.in_ready;  assign t_ovalid[1] = if_b.out_valid;
  assign t_ready[2] = if_c.in_ready;  assign t_ovalid[2] = if_c.out_valid;
  assign t_ready[3] = if_d.in_ready;  assign t_ovalid[3] = if_d.out_valid;
  assign t_odata[0] = if_a.out_data;  assign t_occ[0] = occ_a;  assign t_cnt[0] = cnt_a;
  assign t_odata[1] = if_b.out_data;  assign t_occ[1] = occ_b;  assign t_cnt[1] = cnt_b;
  assign t_odata[2] = if_c.out_data;  assign t_occ[2] = occ_c;  assign t_cnt[2] = cnt_c;
  assign t_odata[3] = if_d.out_data;  assign t_occ[3] = occ_d;  assign t_cnt[3] = {12'h000, cnt_d};

  // Reference model: what item (if any) sits in each slot, plus bubble count
  logic [W-1:0] m_data  [NDUT][N];
  logic         m_valid [NDUT][N];
  int unsigned  m_cnt   [NDUT];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A slot is frozen when it or anything after it is stalled, except that
  // with collapsing an empty slot is always free to accept.
  function automatic logic [N-1:0] frozen(input int d);
    logic [N-1:0] f;
    logic         blocked;
    blocked = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (BC[d] && !m_valid[d][i]) blocked = 1'b0;
      else                         blocked = blocked | stall[i];
      f[i] = blocked;
    end
    return f;
  endfunction

  task automatic compare_all();
    logic [N-1:0] f;
    int           occ;
    for (int d = 0; d < NDUT; d++) begin
      f   = frozen(d);
      occ = 0;
      for (int i = 0; i < N; i++) occ += int'(m_valid[d][i]);
      chk($sformatf("d%0d in_ready", d),   64'(t_ready[d]),  64'(!f[0]));
      chk($sformatf("d%0d out_valid", d),  64'(t_ovalid[d]), 64'(m_valid[d][N-1]));
      chk($sformatf("d%0d out_data", d),   64'(t_odata[d]),  64'(m_data[d][N-1]));
      chk($sformatf("d%0d occupancy", d),  64'(t_occ[d]),    64'(occ));
      chk($sformatf("d%0d bubble_cnt", d), 64'(t_cnt[d]),    64'(m_cnt[d]));
    end
  endtask

  task automatic advance_model();
    logic [N-1:0] f;
    logic [W-1:0] nd [N];
    logic         nv [N];
    logic         sv;
    logic [W-1:0] sd;
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          m_data[d][i]  = '0;
          m_valid[d][i] = 1'b0;
        end
        m_cnt[d] = 0;
      end else begin
        f = frozen(d);
        if (!m_valid[d][N-1] && m_cnt[d] < CMAX[d]) m_cnt[d]++;
        for (int i = 0; i < N; i++) begin
          if (i == 0) begin
            sv = in_valid;
            sd = in_data;
          end else begin
            sv = m_valid[d][i-1] && !f[i-1];
            sd = m_data[d][i-1];
          end
          if (flush[i] && (!FNE[d] || !f[i])) begin
            nv[i] = 1'b0;  nd[i] = '0;
          end else if (f[i]) begin
            nv[i] = m_valid[d][i];  nd[i] = m_data[d][i];
          end else begin
            nv[i] = sv;  nd[i] = sv ? sd : '0;
          end
        end
        for (int i = 0; i < N; i++) begin
          m_data[d][i]  = nd[i];
          m_valid[d][i] = nv[i];
        end
      end
    end
  endtask

  // One cycle: drive inputs at the falling edge, check, then predict the edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] dat,
                      input logic [N-1:0] st, input logic [N-1:0] fl);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = dat;
    stall    = st;
    flush    = fl;
    #1;
    compare_all();
    advance_model();
  endtask

  initial begin
    logic [N-1:0] st, fl;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; stall = '0; flush = '0;
    for (int d = 0; d < NDUT; d++) begin
      m_cnt[d] = 0;
      for (int i = 0; i < N; i++) begin
        m_data[d][i] = '0;  m_valid[d][i] = 1'b0;
      end
    end
    @(posedge clk);
    step(1'b1, 1'b0, '0, '0, '0);

    // Three back-to-back pushes flow out after four cycles
    for (int s = 0; s < 8; s++) begin
      step(1'b0, s < 3, (s < 3) ? W'(32'h11 * (s + 1)) : '0, '0, '0);
      if (s == 0) begin
        chk("reset out_valid", 64'(t_ovalid[0]), 64'd0);
        chk("reset out_data",  64'(t_odata[0]),  64'd0);
        chk("reset occupancy", 64'(t_occ[0]),    64'd0);
        chk("reset in_ready",  64'(t_ready[0]),  64'd1);
        chk("reset cnt",       64'(t_cnt[0]),    64'd0);
      end
      if (s == 3) begin
        chk("lat3 out_valid", 64'(t_ovalid[0]), 64'd0);
        chk("peak occupancy", 64'(t_occ[0]),    64'd3);
      end
      if (s >= 4 && s <= 6) begin
        chk("seq out_valid", 64'(t_ovalid[0]), 64'd1);
        chk("seq out_data",  64'(t_odata[0]),  64'(32'h11 * (s - 3)));
      end
    end

    // Idle after reset: small counter saturates, wide one keeps counting
    step(1'b1, 1'b0, '0, '0, '0);
    for (int s = 0; s <= 20; s++) step(1'b0, 1'b0, '0, '0, '0);
    chk("sat cnt small", 64'(t_cnt[3]), 64'd15);
    chk("sat cnt wide",  64'(t_cnt[0]), 64'd20);

    // Full chain, flush stages 0/1 while stage 1 stalls
    step(1'b1, 1'b0, '0, '0, '0);
    for (int s = 0; s < 4; s++) step(1'b0, 1'b1, W'(32'hA3 - s), '0, '0);
    step(1'b0, 1'b0, '0, 4'b0010, 4'b0011);
    chk("full occupancy", 64'(t_occ[0]), 64'd4);
    step(1'b0, 1'b0, '0, '0, '0);
    chk("flush override occ", 64'(t_occ[0]),   64'd1);
    chk("flush legacy occ",   64'(t_occ[1]),   64'd3);
    chk("flush out_data",     64'(t_odata[1]), 64'hA2);

    // Reset while fully stalled with a full chain
    for (int s = 0; s < 4; s++) step(1'b0, 1'b1, W'(32'hB0 + s), '0, '0);
    step(1'b1, 1'b0, '0, 4'b1111, '0);
    step(1'b0, 1'b0, '0, '0, '0);
    chk("rst stall out_valid", 64'(t_ovalid[0]), 64'd0);
    chk("rst stall out_data",  64'(t_odata[0]),  64'd0);
    chk("rst stall occupancy", 64'(t_occ[0]),    64'd0);
    chk("rst stall cnt",       64'(t_cnt[0]),    64'd0);
    chk("rst stall in_ready",  64'(t_ready[0]),  64'd1);

    // Randomised traffic with stalls, flushes and occasional reset
    for (int s = 0; s < 600; s++) begin
      for (int i = 0; i < N; i++) begin
        st[i] = ($urandom_range(0, 99) < 25);
        fl[i] = ($urandom_range(0, 99) < 8);
      end
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
           W'($urandom), st, fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_reg_chain
`default_nettype wire
